response_collector: RTL and testbench
=====================================

Name: response_collector

Overview:
- Player-side counterpart of the sequence blinker: collects the player's switch entries for one round, one entry at a time.
- For each entry it debounces the switch input, encodes it to a 2-bit colour and reads the stored sequence entry at the current index.
- It compares the two and reports round success, wrong colour or player timeout to the game FSM.
- It drives the sequence-memory address while active; the top level muxes its address and LEDs in with its on_off enable.

Parameters:
- DEBOUNCE_CYC, 1_000_000: consecutive stable cycles required to accept a press or a release (20 ms at 50 MHz).
- TIMEOUT_CYC, 250_000_000: maximum cycles allowed per entry, measured from entering WAIT_PRESS (5 s).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- on_off  in  1  enable; high starts/holds a round, low aborts to IDLE.
- level  in  4  index of the last entry this round; entries 0..level are checked.
- sw  in  4  raw switches SW[3:0], one per colour.
- mem_num  in  2  sequence memory read data for address.
- address  out  4  sequence memory read address.
- led  out  10  player feedback LEDs.
- done  out  1  one-cycle pulse: all level+1 entries matched.
- fail  out  1  one-cycle pulse: mismatch or timeout.
- fail_cause  out  1  valid with fail; 0 = wrong colour, 1 = timeout.

Behaviour:
- Reset (asynchronous, active-low): state IDLE, index 0, all timers 0, address/led/done/fail/fail_cause all 0.
- sw passes through a 2-flop synchronizer first. All decisions use the synchronized value.
- Valid press: exactly one bit set. Encoding: SW[0]→0, SW[1]→1, SW[2]→2, SW[3]→3. Zero bits or multiple bits set is not a press.
- IDLE: index=0, address=0. When on_off=1, go to WAIT_PRESS and clear the timeout counter.
- WAIT_PRESS:
  - Timeout counter increments every cycle.
  - If it reaches TIMEOUT_CYC-1, pulse fail with fail_cause=1 and go to HALT.
  - Otherwise, on a valid press, latch the pattern and go to DEBOUNCE_P.
- DEBOUNCE_P:
  - Timeout keeps counting.
  - If the synchronized sw differs from the latched pattern, return to WAIT_PRESS; the timeout is not cleared.
  - After DEBOUNCE_CYC consecutive equal cycles, latch the code and go to FETCH.
- FETCH: address=index, one cycle. This tolerates a registered memory read.
- CHECK:
  - Compare code with mem_num.
  - Unequal: pulse fail with fail_cause=0 and go to HALT.
  - Equal: go to WAIT_RELEASE.
- WAIT_RELEASE:
  - Requires sw==0 for DEBOUNCE_CYC consecutive cycles; any nonzero value restarts the count. There is no timeout in this state.
  - If index==level: pulse done and go to HALT.
  - Otherwise: index+1, clear the timeout counter, go to WAIT_PRESS.
- HALT: done/fail low; stay until on_off=0.
- on_off=0 in any state: IDLE next cycle, no done/fail pulse, counters cleared.
- address = index in all states except IDLE (0).
- led[3:0] = one-hot of the latched code in CHECK and WAIT_RELEASE, else 0.
- led[8] = 1 in HALT after success; led[9] = 1 in HALT after fail; led[7:4] = 0.
- Outputs are registered. done/fail are high exactly one cycle, in the cycle after the deciding state.
- Counter widths: $clog2(DEBOUNCE_CYC+1) and $clog2(TIMEOUT_CYC+1). Counters saturate and never wrap.
- level=0: a single entry is checked. level=15: 16 entries are checked; index never increments past 15.
- A timeout and press acceptance in the same cycle: timeout wins.

Decomposition:
- Package simon_pkg holds:
  - color_t (2-bit enum: C0..C3)
  - LEVEL_W=4
  - the response_collector state enum (IDLE, WAIT_PRESS, DEBOUNCE_P, FETCH, CHECK, WAIT_RELEASE, HALT)
  - the fail-cause constants.
- One sub-module, sw_debouncer: synchronizer plus stable-count for a given target pattern. Parameter DEBOUNCE_CYC; outputs the synchronized pattern and a stable flag. It is instantiated once and reused for press and release.

Test Plan:
- All scenarios use DEBOUNCE_CYC=4 and TIMEOUT_CYC=100.
- Memory {2,0,3}, level=2, player presses SW[2], SW[0], SW[3], each held 10 cycles with 10-cycle releases → single done pulse; address steps 0,1,2; led[8]=1; fail never asserted.
- Memory {1,…}, player presses SW[3] → fail pulse, fail_cause=0, led[9]=1, led[3]=1 in CHECK; stays HALT until on_off=0.
- No input after on_off rises → fail with fail_cause=1 exactly 100 cycles after WAIT_PRESS entry (±synchronizer latency documented).
- SW=4'b0101 held 50 cycles, then a 2-cycle SW[1] glitch → no FETCH entered; a subsequent clean SW[1] press is accepted.
- on_off dropped mid-WAIT_RELEASE at index 1 → IDLE next cycle, address=0, no pulse. reset asserted mid-DEBOUNCE_P → all outputs 0 immediately, asynchronously.
- level=0, memory[0]=3, press SW[3] → done after release debounce; index stays 0.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game blocks.
//   color_t      : 2-bit colour code, one per switch/LED.
//   LEVEL_W      : width of the round index / level.
//   rc_state_t   : response_collector FSM states.
//   FAIL_*       : values carried on fail_cause alongside a fail pulse.
//   is_press     : true when exactly one switch is set.
//   encode_sw    : one-hot switch pattern -> colour code.
//   color_led    : colour code -> one-hot LED pattern.
package simon_pkg;

    localparam int LEVEL_W = 4;

    typedef enum logic [1:0] {
        C0 = 2'd0,
        C1 = 2'd1,
        C2 = 2'd2,
        C3 = 2'd3
    } color_t;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_PRESS   = 3'd1,
        DEBOUNCE_P   = 3'd2,
        FETCH        = 3'd3,
        CHECK        = 3'd4,
        WAIT_RELEASE = 3'd5,
        HALT         = 3'd6
    } rc_state_t;

    localparam logic FAIL_WRONG   = 1'b0;
    localparam logic FAIL_TIMEOUT = 1'b1;

    function automatic logic is_press(input logic [3:0] sw);
        return (sw != 4'b0000) && ((sw & (sw - 4'd1)) == 4'b0000);
    endfunction

    // Only meaningful for a one-hot pattern; the highest set bit wins otherwise.
    function automatic color_t encode_sw(input logic [3:0] sw);
        color_t c;
        c = C0;
        if (sw[1]) c = C1;
        if (sw[2]) c = C2;
        if (sw[3]) c = C3;
        return c;
    endfunction

    function automatic logic [3:0] color_led(input color_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/sw_debouncer.sv
// Two-flop synchronizer plus a consecutive-match counter.
//   clk, reset : clock, asynchronous active-low reset.
//   sw_raw     : raw switch inputs.
//   target     : pattern the synchronized switches must hold.
//   restart    : clears the match count (held while nobody is debouncing).
//   sw_sync    : synchronized switch pattern.
//   stable     : high in the cycle that completes DEBOUNCE_CYC consecutive
//                cycles of sw_sync == target since the last restart.
module sw_debouncer #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw_raw,
    input  logic [3:0] target,
    input  logic       restart,
    output logic [3:0] sw_sync,
    output logic       stable
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [3:0]       sync_1;
    logic [CNT_W-1:0] cnt;
    logic             match;

    assign match  = (sw_sync == target);
    // The current matching cycle is the DEBOUNCE_CYC-th once cnt holds the
    // previous DEBOUNCE_CYC-1 matches.
    assign stable = match && !restart && (cnt >= CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1  <= 4'b0000;
            sw_sync <= 4'b0000;
            cnt     <= '0;
        end else begin
            sync_1  <= sw_raw;
            sw_sync <= sync_1;
            if (restart || !match) begin
                cnt <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/response_collector.sv
// Collects the player's switch entries for one Simon round and checks each
// against the stored sequence.
//   clk, reset  : clock, asynchronous active-low reset.
//   on_off      : high runs/holds a round, low aborts to IDLE.
//   level       : index of the last entry checked this round.
//   sw          : raw player switches, one per colour.
//   mem_num     : sequence memory read data for address.
//   address     : sequence memory read address (index, 0 in IDLE).
//   led         : [3:0] entered colour, [8] round won, [9] round lost.
//   done        : one-cycle pulse, all entries matched.
//   fail        : one-cycle pulse, wrong colour or timeout.
//   fail_cause  : valid with fail, FAIL_WRONG or FAIL_TIMEOUT.
//   dbg_state   : current FSM state.
// All outputs are registered: they are computed from the next-state values.
module response_collector
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int TIMEOUT_CYC  = 250_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               on_off,
    input  logic [LEVEL_W-1:0] level,
    input  logic [3:0]         sw,
    input  logic [1:0]         mem_num,
    output logic [LEVEL_W-1:0] address,
    output logic [9:0]         led,
    output logic               done,
    output logic               fail,
    output logic               fail_cause,
    output rc_state_t          dbg_state
);

    localparam int            TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [9:0]    LED_WIN  = 10'b01_0000_0000;
    localparam logic [9:0]    LED_LOSE = 10'b10_0000_0000;

    rc_state_t          state_q, state_n;
    logic [LEVEL_W-1:0] index_q, index_n;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_n;
    logic [3:0]         pat_q, pat_n;
    color_t             code_q, code_n;
    logic [LEVEL_W-1:0] address_n;
    logic [9:0]         led_n;
    logic               done_n, fail_n, cause_n;

    logic [3:0] sw_sync;
    logic [3:0] deb_target;
    logic       deb_restart;
    logic       deb_stable;

    // One debouncer serves both phases: the latched press pattern while
    // debouncing a press, all-zero while waiting for the release.
    assign deb_target  = (state_q == WAIT_RELEASE) ? 4'b0000 : pat_q;
    assign deb_restart = !((state_q == DEBOUNCE_P) || (state_q == WAIT_RELEASE));

    sw_debouncer #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debouncer (
        .clk    (clk),
        .reset  (reset),
        .sw_raw (sw),
        .target (deb_target),
        .restart(deb_restart),
        .sw_sync(sw_sync),
        .stable (deb_stable)
    );

    assign dbg_state = state_q;

    always_comb begin
        state_n  = state_q;
        index_n  = index_q;
        to_cnt_n = to_cnt_q;
        pat_n    = pat_q;
        code_n   = code_q;
        done_n   = 1'b0;
        fail_n   = 1'b0;
        cause_n  = 1'b0;
        led_n    = 10'b0;

        if (!on_off) begin
            state_n  = IDLE;
            index_n  = '0;
            to_cnt_n = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    index_n  = '0;
                    to_cnt_n = '0;
                    state_n  = WAIT_PRESS;
                end
                WAIT_PRESS: begin
                    // Timeout is checked first so it wins over a press.
                    if (to_cnt_q >= TO_LAST) begin
                        fail_n  = 1'b1;
                        cause_n = FAIL_TIMEOUT;
                        led_n   = LED_LOSE;
                        state_n = HALT;
                    end else begin
                        to_cnt_n = to_cnt_q + 1'b1;
                        if (is_press(sw_sync)) begin
                            pat_n   = sw_sync;
                            state_n = DEBOUNCE_P;
                        end
                    end
                end
                DEBOUNCE_P: begin
                    if (to_cnt_q >= TO_LAST) begin
                        fail_n  = 1'b1;
                        cause_n = FAIL_TIMEOUT;
                        led_n   = LED_LOSE;
                        state_n = HALT;
                    end else begin
                        to_cnt_n = to_cnt_q + 1'b1;
                        if (sw_sync != pat_q) begin
                            state_n = WAIT_PRESS;
                        end else if (deb_stable) begin
                            code_n  = encode_sw(pat_q);
                            state_n = FETCH;
                        end
                    end
                end
                FETCH: begin
                    // Address already shows index; this cycle lets a
                    // registered memory return mem_num.
                    state_n = CHECK;
                end
                CHECK: begin
                    if (code_q != color_t'(mem_num)) begin
                        fail_n  = 1'b1;
                        cause_n = FAIL_WRONG;
                        led_n   = LED_LOSE;
                        state_n = HALT;
                    end else begin
                        state_n = WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (deb_stable) begin
                        if (index_q == level) begin
                            done_n  = 1'b1;
                            led_n   = LED_WIN;
                            state_n = HALT;
                        end else begin
                            index_n  = index_q + 1'b1;
                            to_cnt_n = '0;
                            state_n  = WAIT_PRESS;
                        end
                    end
                end
                HALT: begin
                    led_n = led;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase

            if ((state_n == CHECK) || (state_n == WAIT_RELEASE)) begin
                led_n = {6'b0, color_led(code_n)};
            end
        end

        address_n = (state_n == IDLE) ? '0 : index_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            index_q    <= '0;
            to_cnt_q   <= '0;
            pat_q      <= 4'b0000;
            code_q     <= C0;
            address    <= '0;
            led        <= 10'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_cause <= 1'b0;
        end else begin
            state_q    <= state_n;
            index_q    <= index_n;
            to_cnt_q   <= to_cnt_n;
            pat_q      <= pat_n;
            code_q     <= code_n;
            address    <= address_n;
            led        <= led_n;
            done       <= done_n;
            fail       <= fail_n;
            fail_cause <= cause_n;
        end
    end

endmodule

// File: tb/tb_response_collector.sv
// Directed bench for response_collector with DEBOUNCE_CYC=4, TIMEOUT_CYC=100.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_response_collector;
    import simon_pkg::*;

    localparam int DEB = 4;
    localparam int TO  = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       on_off = 1'b0;
    logic [3:0] level = 4'd0;
    logic [3:0] sw = 4'd0;
    logic [1:0] mem_num;
    logic [3:0] address;
    logic [9:0] led;
    logic       done, fail, fail_cause;
    rc_state_t  dbg_state;

    logic [1:0] mem [16];
    assign mem_num = mem[address];

    response_collector #(
        .DEBOUNCE_CYC(DEB),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .on_off    (on_off),
        .level     (level),
        .sw        (sw),
        .mem_num   (mem_num),
        .address   (address),
        .led       (led),
        .done      (done),
        .fail      (fail),
        .fail_cause(fail_cause),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         fail_cnt = 0;
    int         dbl_pulse = 0;
    logic       prev_done = 1'b0;
    logic       prev_fail = 1'b0;
    logic       last_cause = 1'b0;
    logic [9:0] chk_led = 10'b0;
    logic [3:0] fetch_q[$];
    logic [3:0] exp_q[$];

    typedef struct {
        logic [1:0] mem0;
        logic [3:0] sw_val;
        int         hold;
        logic       exp_done;
        logic       exp_fail;
        logic       exp_cause;
        logic [9:0] exp_chk_led;
        logic [9:0] exp_halt_led;
    } vec_t;

    vec_t vecs[7];

    // ---------------- driver / sampler tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
        if (fail === 1'b1) begin
            fail_cnt++;
            last_cause = fail_cause;
        end
        if ((done && prev_done) || (fail && prev_fail)) dbl_pulse++;
        prev_done = done;
        prev_fail = fail;
        if (dbg_state == CHECK) chk_led = led;
        if (dbg_state == FETCH) fetch_q.push_back(address);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic hold(input logic [3:0] val, input int n);
        sw = val;
        steps(n);
    endtask

    task automatic do_reset();
        on_off = 1'b0;
        sw     = 4'd0;
        reset  = 1'b0;
        steps(2);
        reset  = 1'b1;
        step();
    endtask

    task automatic wait_state(input rc_state_t s, input int budget, input string name);
        int n;
        n = 0;
        while (dbg_state != s && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(dbg_state), 32'(s));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int d0;
        int f0;

        for (int i = 0; i < 16; i++) mem[i] = 2'd0;

        //                mem0   sw       hold done  fail  cause chk_led  halt_led
        vecs[0] = '{2'd0, 4'b0001, 10, 1'b1, 1'b0, 1'b0, 10'h001, 10'h100};
        vecs[1] = '{2'd1, 4'b0010, 10, 1'b1, 1'b0, 1'b0, 10'h002, 10'h100};
        vecs[2] = '{2'd2, 4'b0100, 10, 1'b1, 1'b0, 1'b0, 10'h004, 10'h100};
        vecs[3] = '{2'd3, 4'b1000, 10, 1'b1, 1'b0, 1'b0, 10'h008, 10'h100};
        vecs[4] = '{2'd0, 4'b1000, 10, 1'b0, 1'b1, 1'b0, 10'h008, 10'h200};
        vecs[5] = '{2'd2, 4'b0001, 10, 1'b0, 1'b1, 1'b0, 10'h001, 10'h200};
        vecs[6] = '{2'd1, 4'b0011, 150, 1'b0, 1'b1, 1'b1, 10'h000, 10'h200};

        // Reset values
        do_reset();
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_outputs", {17'd0, address, led, done, fail, fail_cause}, 32'd0);

        // Table: single-entry rounds (level 0)
        for (int v = 0; v < 7; v++) begin
            on_off = 1'b0;
            sw     = 4'd0;
            steps(3);
            mem[0]     = vecs[v].mem0;
            level      = 4'd0;
            d0         = done_cnt;
            f0         = fail_cnt;
            chk_led    = 10'b0;
            last_cause = 1'b0;
            on_off     = 1'b1;
            hold(vecs[v].sw_val, vecs[v].hold);
            hold(4'd0, 20);
            wait_state(HALT, 300, $sformatf("vec%0d_halt", v));
            check($sformatf("vec%0d_done", v), 32'(done_cnt - d0), 32'(vecs[v].exp_done));
            check($sformatf("vec%0d_fail", v), 32'(fail_cnt - f0), 32'(vecs[v].exp_fail));
            check($sformatf("vec%0d_cause", v), 32'(last_cause), 32'(vecs[v].exp_cause));
            check($sformatf("vec%0d_chk_led", v), 32'(chk_led), 32'(vecs[v].exp_chk_led));
            check($sformatf("vec%0d_halt_led", v), 32'(led), 32'(vecs[v].exp_halt_led));
            check($sformatf("vec%0d_addr", v), 32'(address), 32'd0);
        end

        // Three-entry round {2,0,3}, level 2
        do_reset();
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
        level = 4'd2;
        fetch_q.delete();
        exp_q.delete();
        exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd2);
        d0 = done_cnt;
        f0 = fail_cnt;
        on_off = 1'b1;
        hold(4'b0100, 10); hold(4'd0, 10);
        hold(4'b0001, 10); hold(4'd0, 10);
        hold(4'b1000, 10); hold(4'd0, 10);
        wait_state(HALT, 100, "seq3_halt");
        check("seq3_done", 32'(done_cnt - d0), 32'd1);
        check("seq3_fail", 32'(fail_cnt - f0), 32'd0);
        check("seq3_led", 32'(led), 32'h100);
        check("seq3_addr_halt", 32'(address), 32'd2);
        check("seq3_fetch_cnt", 32'(fetch_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && fetch_q.size() > 0) begin
            check("seq3_fetch_addr", 32'(fetch_q.pop_front()), 32'(exp_q.pop_front()));
        end

        // Wrong colour: mem[0]=1, press SW[3]; HALT holds until on_off drops
        do_reset();
        mem[0] = 2'd1;
        level = 4'd2;
        chk_led = 10'b0;
        d0 = done_cnt;
        f0 = fail_cnt;
        on_off = 1'b1;
        hold(4'b1000, 10); hold(4'd0, 10);
        wait_state(HALT, 100, "wrong_halt");
        check("wrong_fail", 32'(fail_cnt - f0), 32'd1);
        check("wrong_cause", 32'(last_cause), 32'(FAIL_WRONG));
        check("wrong_chk_led", 32'(chk_led), 32'h008);
        steps(20);
        check("wrong_stay_halt", 32'(dbg_state), 32'(HALT));
        check("wrong_stay_led", 32'(led), 32'h200);
        check("wrong_single_fail", 32'(fail_cnt - f0), 32'd1);
        check("wrong_no_done", 32'(done_cnt - d0), 32'd0);
        on_off = 1'b0;
        step();
        check("wrong_to_idle", 32'(dbg_state), 32'(IDLE));
        check("wrong_idle_led", 32'(led), 32'd0);

        // Timeout: no input after on_off rises
        do_reset();
        mem[0] = 2'd0;
        level = 4'd0;
        f0 = fail_cnt;
        on_off = 1'b1;
        wait_state(WAIT_PRESS, 10, "to_entry");
        n = 0;
        while (fail_cnt == f0 && n < 300) begin
            step();
            n++;
        end
        check("to_latency", 32'(n), 32'(TO));
        check("to_cause", 32'(last_cause), 32'(FAIL_TIMEOUT));
        check("to_led", 32'(led), 32'h200);

        // Multi-bit hold then a 2-cycle glitch: no FETCH; clean press accepted
        do_reset();
        mem[0] = 2'd1;
        level = 4'd0;
        fetch_q.delete();
        d0 = done_cnt;
        on_off = 1'b1;
        hold(4'b0101, 50);
        hold(4'b0010, 2);
        hold(4'd0, 5);
        check("glitch_no_fetch", 32'(fetch_q.size()), 32'd0);
        check("glitch_wait_press", 32'(dbg_state), 32'(WAIT_PRESS));
        hold(4'b0010, 10);
        hold(4'd0, 10);
        wait_state(HALT, 50, "glitch_halt");
        check("glitch_done", 32'(done_cnt - d0), 32'd1);
        check("glitch_fetch_cnt", 32'(fetch_q.size()), 32'd1);

        // on_off dropped in WAIT_RELEASE at index 1
        do_reset();
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
        level = 4'd2;
        on_off = 1'b1;
        hold(4'b0100, 10); hold(4'd0, 10);
        sw = 4'b0001;
        n = 0;
        while (!(dbg_state == WAIT_RELEASE && address == 4'd1) && n < 40) begin
            step();
            n++;
        end
        check("abort_in_wr", 32'(dbg_state), 32'(WAIT_RELEASE));
        check("abort_wr_led", 32'(led), 32'h001);
        d0 = done_cnt;
        f0 = fail_cnt;
        on_off = 1'b0;
        step();
        check("abort_idle", 32'(dbg_state), 32'(IDLE));
        check("abort_addr", 32'(address), 32'd0);
        check("abort_led", 32'(led), 32'd0);
        steps(5);
        check("abort_no_pulse", 32'((done_cnt - d0) + (fail_cnt - f0)), 32'd0);

        // Asynchronous reset during DEBOUNCE_P at index 1
        do_reset();
        on_off = 1'b1;
        hold(4'b0100, 10); hold(4'd0, 10);
        sw = 4'b0001;
        n = 0;
        while (!(dbg_state == DEBOUNCE_P && address == 4'd1) && n < 40) begin
            step();
            n++;
        end
        check("arst_pre_addr", 32'(address), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_state", 32'(dbg_state), 32'(IDLE));
        check("arst_outputs", {17'd0, address, led, done, fail, fail_cause}, 32'd0);
        step();
        reset = 1'b1;
        on_off = 1'b0;
        sw = 4'd0;

        // level 0, mem[0]=3, press SW[3]
        do_reset();
        mem[0] = 2'd3;
        level = 4'd0;
        fetch_q.delete();
        d0 = done_cnt;
        on_off = 1'b1;
        hold(4'b1000, 10);
        hold(4'd0, 10);
        wait_state(HALT, 50, "lvl0_halt");
        check("lvl0_done", 32'(done_cnt - d0), 32'd1);
        check("lvl0_addr", 32'(address), 32'd0);
        check("lvl0_fetch_cnt", 32'(fetch_q.size()), 32'd1);
        check("lvl0_led", 32'(led), 32'h100);

        // No done/fail pulse was ever longer than one cycle
        check("pulse_width", 32'(dbl_pulse), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
